sequenciador_entrada: RTL
=========================

Name: sequenciador_entrada

Overview:
- Controller that sequences the 6-bit input of the combinational 7-segment decoder, `Integracao`.
- Steps `entrada` through a programmable range and holds each value for DWELL clock cycles.
- Captures the decoder's `segmentos` at the end of each hold.
- Supports start, pause, single-step and cyclic modes.
- Replaces the hand-written stimulus sequence, so the decoder can run self-driven on hardware or in simulation.

Parameters:
- LARGURA, 6, width of `entrada` and of the range bounds.
- DWELL, 10, cycles each value is held; legal range ≥1.
- NSEG, 7, width of the segment bus.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- iniciar  in  1  single-cycle start pulse; sampled only in OCIOSO or FIM.
- pausar  in  1  level; holds the sequence while high.
- passo  in  1  single-cycle pulse; advances one value while paused.
- ciclico  in  1  1 = restart at `valor_inicial` after `valor_final`; 0 = stop.
- valor_inicial  in  LARGURA  first value; latched on accepted `iniciar`.
- valor_final  in  LARGURA  last value; latched on accepted `iniciar`.
- segmentos_in  in  NSEG  decoder output, combinational from `entrada`.
- entrada  out  LARGURA  value driven to the decoder.
- ocupado  out  1  high in CARREGA, EXIBE and PAUSA.
- amostra  out  NSEG  registered capture of `segmentos_in`.
- amostra_valida  out  1  one-cycle pulse when `amostra` updates.
- concluido  out  1  one-cycle pulse on entry to FIM.

Behaviour:
- Reset: all outputs are 0. State = OCIOSO. Dwell counter = 0. Latched bounds = 0.
- All outputs are registered.
- States: OCIOSO, CARREGA, EXIBE, PAUSA, FIM.
- OCIOSO, on `iniciar`:
  - latch `valor_inicial`/`valor_final`;
  - `entrada` <= `valor_inicial`;
  - go to CARREGA.
- CARREGA: one cycle, so the decoder settles. Dwell counter <= 0. Go to EXIBE.
- EXIBE: counter increments each cycle. When counter == DWELL-1:
  - `amostra` <= `segmentos_in` and pulse `amostra_valida`;
  - if `entrada` == latched final:
    - `ciclico`=1: `entrada` <= latched initial, counter <= 0, stay in EXIBE;
    - `ciclico`=0: go to FIM and pulse `concluido`;
  - otherwise `entrada` <= `entrada`+1 mod 2^LARGURA, counter <= 0.
- Timing: the first sample comes DWELL+1 cycles after the `iniciar` edge. Later samples come every DWELL cycles.
- Range: increment wraps modulo 2^LARGURA. If final < initial, the sequence passes through 63→0. Values visited = ((final − initial) mod 2^LARGURA) + 1. Equal bounds give a single value.
- `pausar` high in EXIBE, checked before the dwell test:
  - go to PAUSA;
  - counter frozen;
  - no sample taken that cycle.
- PAUSA:
  - `pausar` low: return to EXIBE; the counter resumes where it stopped.
  - `passo` pulse with `pausar` high: force an end-of-dwell action (sample, then advance, wrap or finish) and stay in PAUSA. If that action would finish, go to FIM.
- FIM:
  - `entrada` holds the last value and `ocupado`=0.
  - `iniciar` restarts exactly as from OCIOSO.
- Ignored inputs:
  - `iniciar` while `ocupado`=1.
  - `passo` outside PAUSA.
- Simultaneous `iniciar` and `pausar` in OCIOSO: the start is accepted. The sequence goes CARREGA → EXIBE, then to PAUSA on the first EXIBE cycle.
- Bound changes after latch: no effect until the next accepted `iniciar`.
- `rst_n` low at any time: immediate return to the reset values; any sequence in progress is abandoned.
- DWELL=1: one sample per cycle in EXIBE.

Decomposition:
- Package `sequenciador_pkg`:
  - state encoding enum (OCIOSO=0 … FIM=4);
  - default LARGURA/NSEG constants.
- Sub-module `contador_permanencia`: dwell counter with clear, enable and terminal-count output, parameterised by DWELL.
- The FSM and the `entrada`/capture registers stay in the top module.
- Integration wrapper instantiates `sequenciador_entrada` plus `Integracao`, with `entrada`→`entrada` and `segmentos`→`segmentos_in`.

Test Plan:
- Full sweep: DWELL=10, inicial=0, final=63, ciclico=0, `iniciar` pulse → 64 `amostra_valida` pulses 10 cycles apart. Sample k equals the decoder pattern for k. `concluido` fires once, `entrada`=63, `ocupado`=0.
- Wrap range: inicial=62, final=1, ciclico=0 → samples for 62, 63, 0, 1, then `concluido`.
- Cyclic: inicial=5, final=7, ciclico=1, run 10 samples → values 5, 6, 7, 5, 6, 7, 5, 6, 7, 5. `concluido` never asserted.
- Pause/step: raise `pausar` mid-dwell at counter=4 → no samples while held. Three `passo` pulses → exactly 3 samples with `entrada` advancing by 1 each. Release → the next sample arrives DWELL−4 cycles later.
- Ignored start: `iniciar` mid-sequence with different bounds → sequence unchanged and bounds unchanged.
- Reset mid-run: assert `rst_n`=0 at `entrada`=20 → outputs are 0 within the same cycle, asynchronously. After release, state = OCIOSO, with no spurious pulses.

Source files
------------

// File: rtl/sequenciador_pkg.sv
// Shared definitions for the entrada sequencer: state encoding and default sizes.
package sequenciador_pkg;

    localparam int LARGURA_PADRAO = 6;
    localparam int NSEG_PADRAO    = 7;
    localparam int DWELL_PADRAO   = 10;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        EXIBE   = 3'd2,
        PAUSA   = 3'd3,
        FIM     = 3'd4
    } estado_t;

    // True for the states in which a sequence is in progress.
    function automatic logic ocupado_em(input estado_t e);
        return (e == CARREGA) || (e == EXIBE) || (e == PAUSA);
    endfunction

endpackage

// File: rtl/contador_permanencia.sv
// Dwell counter: counts 0..DWELL-1 while enabled, wraps to 0 after the
// terminal count, and flags the terminal count combinationally from the register.
module contador_permanencia #(
    parameter int DWELL = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic limpar,
    input  logic habilitar,
    output logic terminal
);

    localparam int            CW     = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(DWELL - 1);

    logic [CW-1:0] contagem_r;

    // Count register: clear has priority, otherwise advance and wrap while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contagem_r <= '0;
        end else if (limpar) begin
            contagem_r <= '0;
        end else if (habilitar) begin
            if (contagem_r == ULTIMO) begin
                contagem_r <= '0;
            end else begin
                contagem_r <= contagem_r + CW'(1);
            end
        end
    end

    assign terminal = (contagem_r == ULTIMO);

endmodule

// File: rtl/sequenciador_entrada.sv
// Sequencer that drives the 7-segment decoder input through a latched range,
// holding each value DWELL cycles and capturing the decoder output at the end
// of each hold. Supports pause, single-step and cyclic operation.
module sequenciador_entrada
    import sequenciador_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO,
    parameter int DWELL   = DWELL_PADRAO,
    parameter int NSEG    = NSEG_PADRAO
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               iniciar,
    input  logic               pausar,
    input  logic               passo,
    input  logic               ciclico,
    input  logic [LARGURA-1:0] valor_inicial,
    input  logic [LARGURA-1:0] valor_final,
    input  logic [NSEG-1:0]    segmentos_in,
    output logic [LARGURA-1:0] entrada,
    output logic               ocupado,
    output logic [NSEG-1:0]    amostra,
    output logic               amostra_valida,
    output logic               concluido
);

    estado_t            estado_r, estado_s;
    logic [LARGURA-1:0] inicial_r, inicial_s;
    logic [LARGURA-1:0] final_r, final_s;
    logic [LARGURA-1:0] entrada_s;
    logic [NSEG-1:0]    amostra_s;
    logic               amostra_valida_s;
    logic               concluido_s;
    logic               ocupado_s;
    logic               limpar_s;
    logic               habilitar_s;
    logic               terminal_s;
    logic               acao_s;

    contador_permanencia #(
        .DWELL(DWELL)
    ) u_contador (
        .clk      (clk),
        .rst_n    (rst_n),
        .limpar   (limpar_s),
        .habilitar(habilitar_s),
        .terminal (terminal_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_r <= OCIOSO;
        end else begin
            estado_r <= estado_s;
        end
    end

    // Next-state, bound latching and end-of-dwell action.
    always_comb begin
        estado_s         = estado_r;
        inicial_s        = inicial_r;
        final_s          = final_r;
        entrada_s        = entrada;
        amostra_s        = amostra;
        amostra_valida_s = 1'b0;
        concluido_s      = 1'b0;
        limpar_s         = 1'b0;
        habilitar_s      = 1'b0;
        acao_s           = 1'b0;

        case (estado_r)
            OCIOSO, FIM: begin
                if (iniciar) begin
                    inicial_s = valor_inicial;
                    final_s   = valor_final;
                    entrada_s = valor_inicial;
                    estado_s  = CARREGA;
                end else begin
                    estado_s  = estado_r;
                end
            end
            CARREGA: begin
                limpar_s = 1'b1;
                estado_s = EXIBE;
            end
            EXIBE: begin
                // Pause wins over the dwell test: counter frozen, no sample.
                if (pausar) begin
                    estado_s = PAUSA;
                end else begin
                    habilitar_s = 1'b1;
                    acao_s      = terminal_s;
                end
            end
            PAUSA: begin
                // A step forces the end-of-dwell action but leaves the counter
                // untouched, so the interrupted hold resumes where it stopped.
                if (!pausar) begin
                    estado_s = EXIBE;
                end else if (passo) begin
                    acao_s   = 1'b1;
                end else begin
                    estado_s = PAUSA;
                end
            end
            default: begin
                estado_s = OCIOSO;
            end
        endcase

        if (acao_s) begin
            amostra_s        = segmentos_in;
            amostra_valida_s = 1'b1;
            if (entrada == final_r) begin
                if (ciclico) begin
                    entrada_s = inicial_r;
                end else begin
                    estado_s    = FIM;
                    concluido_s = 1'b1;
                end
            end else begin
                entrada_s = entrada + LARGURA'(1);
            end
        end else begin
            amostra_valida_s = 1'b0;
        end

        ocupado_s = ocupado_em(estado_s);
    end

    // Output and latched-bound registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inicial_r      <= '0;
            final_r        <= '0;
            entrada        <= '0;
            amostra        <= '0;
            amostra_valida <= 1'b0;
            concluido      <= 1'b0;
            ocupado        <= 1'b0;
        end else begin
            inicial_r      <= inicial_s;
            final_r        <= final_s;
            entrada        <= entrada_s;
            amostra        <= amostra_s;
            amostra_valida <= amostra_valida_s;
            concluido      <= concluido_s;
            ocupado        <= ocupado_s;
        end
    end

endmodule
